// File: rtl/branch_pkg.sv
// branch_pkg: shared FSM states, branch-condition encodings and predictor init value.
package branch_pkg;
    typedef enum logic {IDLE, PEND} state_t;
    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_EQ   = 3'b001,
        BR_NE   = 3'b010,
        BR_LT   = 3'b011,
        BR_LTU  = 3'b100,
        BR_GE   = 3'b101,
        BR_GEU  = 3'b110
    } bra_con_t;
    localparam logic [1:0] PHT_INIT = 2'b01;
endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// branch_redirect_ctrl_if: EX-resolve inputs, fetch lookup and redirect/flush/counter outputs.
interface branch_redirect_ctrl_if #(parameter int XLEN = 32, parameter int CNT_W = 32);
    logic             if_pc_unused_guard;
    logic [XLEN-1:0]  if_pc;
    logic             if_pred_taken;
    logic             ex_valid;
    logic             ex_is_branch;
    logic             ex_is_jump;
    logic             ex_pred_taken;
    logic             branch_tk;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_target;
    logic             stall_in;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;

    modport master (
        output if_pc, ex_valid, ex_is_branch, ex_is_jump, ex_pred_taken, branch_tk,
               ex_pc, ex_target, stall_in,
        input  if_pred_taken, redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
               br_count, mispred_count
    );
    modport slave (
        input  if_pc, ex_valid, ex_is_branch, ex_is_jump, ex_pred_taken, branch_tk,
               ex_pc, ex_target, stall_in,
        output if_pred_taken, redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
               br_count, mispred_count
    );
endinterface

// File: rtl/bimodal_pht.sv
// bimodal_pht: 2-bit saturating counter table with a combinational lookup and a synchronous update.
module bimodal_pht
    import branch_pkg::*;
#(
    parameter int ENTRIES = 16,
    localparam int IW = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] i_rd_idx,
    output logic          o_rd_taken,
    input  logic          i_wr_en,
    input  logic [IW-1:0] i_wr_idx,
    input  logic          i_wr_taken
);
    logic [1:0] r_pht [ENTRIES];
    logic [1:0] w_cur;
    logic [1:0] w_nxt;

    assign o_rd_taken = r_pht[i_rd_idx][1];
    assign w_cur      = r_pht[i_wr_idx];
    assign w_nxt      = i_wr_taken ? (w_cur == 2'b11 ? w_cur : w_cur + 2'd1)
                                   : (w_cur == 2'b00 ? w_cur : w_cur - 2'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) r_pht[i] <= PHT_INIT;
        end else if (i_wr_en) begin
            r_pht[i_wr_idx] <= w_nxt;
        end
    end
endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: resolves EX branches against the prediction, issues a registered
// redirect with pipeline flushes, trains the bimodal table and counts branches/mispredicts.
module branch_redirect_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PHT_ENTRIES = 16,
    parameter int CNT_W       = 32
) (
    input logic                  clk,
    input logic                  rst,
    branch_redirect_ctrl_if.slave bus
);
    localparam int IW = $clog2(PHT_ENTRIES);

    state_t           r_state;
    state_t           w_next;
    logic [XLEN-1:0]  r_redirect_pc;
    logic [CNT_W-1:0] r_br_count;
    logic [CNT_W-1:0] r_mispred_count;
    logic             w_resolve;
    logic             w_cond;
    logic             w_actual;
    logic             w_mispred;
    logic             w_unused;

    assign w_resolve = r_state == IDLE && bus.ex_valid && !bus.stall_in
                       && (bus.ex_is_branch || bus.ex_is_jump);
    // A branch+jump combination is treated as a jump: no training, no branch count.
    assign w_cond    = w_resolve && bus.ex_is_branch && !bus.ex_is_jump;
    assign w_actual  = bus.ex_is_jump || bus.branch_tk;
    assign w_mispred = w_resolve && (w_actual != bus.ex_pred_taken);
    assign w_unused  = ^{bus.if_pc[XLEN-1:IW+2], bus.if_pc[1:0]};

    bimodal_pht #(.ENTRIES(PHT_ENTRIES)) u_pht (
        .clk       (clk),
        .rst       (rst),
        .i_rd_idx  (bus.if_pc[IW+1:2]),
        .o_rd_taken(bus.if_pred_taken),
        .i_wr_en   (w_cond),
        .i_wr_idx  (bus.ex_pc[IW+1:2]),
        .i_wr_taken(bus.branch_tk)
    );

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE) w_next = w_mispred ? PEND : IDLE;
        else                 w_next = bus.stall_in ? PEND : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_redirect_pc   <= '0;
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_mispred) begin
                r_redirect_pc   <= w_actual ? bus.ex_target : bus.ex_pc + XLEN'(4);
                r_mispred_count <= r_mispred_count + CNT_W'(1);
            end
            if (w_cond) r_br_count <= r_br_count + CNT_W'(1);
        end
    end

    assign bus.redirect_valid = r_state == PEND;
    assign bus.flush_if_id    = r_state == PEND;
    assign bus.flush_id_ex    = r_state == PEND;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.br_count       = r_br_count;
    assign bus.mispred_count  = r_mispred_count;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed and random stimulus checked against a behavioural model.
module tb_branch_redirect_ctrl;
    localparam int CW = 4;

    logic clk = 0;
    logic rst = 1;
    int   errors = 0;
    int   checks = 0;

    int          m_pht [16];
    bit          m_pend;
    logic [31:0] m_rpc;
    int          m_brc;
    int          m_mpc;

    branch_redirect_ctrl_if #(.XLEN(32), .CNT_W(CW)) bus ();

    branch_redirect_ctrl #(.XLEN(32), .PHT_ENTRIES(16), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pht[i] = 1;
        m_pend = 0;
        m_rpc  = 0;
        m_brc  = 0;
        m_mpc  = 0;
    endtask

    task automatic check_all();
        chk("pred",    32'(bus.if_pred_taken),  32'(m_pht[bus.if_pc[5:2]] >= 2));
        chk("rv",      32'(bus.redirect_valid), 32'(m_pend));
        chk("fl_ifid", 32'(bus.flush_if_id),    32'(m_pend));
        chk("fl_idex", 32'(bus.flush_id_ex),    32'(m_pend));
        chk("rpc",     bus.redirect_pc,         m_rpc);
        chk("brc",     32'(bus.br_count),       32'(m_brc));
        chk("mpc",     32'(bus.mispred_count),  32'(m_mpc));
    endtask

    // One cycle: apply inputs, check pre-edge outputs, clock, advance the model.
    task automatic cyc(input logic v, input logic br, input logic j, input logic pt,
                       input logic tk, input logic [31:0] epc, input logic [31:0] tgt,
                       input logic [31:0] ipc, input logic st);
        bit act;
        int ix;
        bus.ex_valid = v; bus.ex_is_branch = br; bus.ex_is_jump = j;
        bus.ex_pred_taken = pt; bus.branch_tk = tk; bus.ex_pc = epc;
        bus.ex_target = tgt; bus.if_pc = ipc; bus.stall_in = st;
        #1;
        check_all();
        @(posedge clk);
        if (m_pend) begin
            if (!st) m_pend = 0;
        end else if (v && !st && (br || j)) begin
            act = j || tk;
            ix  = int'(epc[5:2]);
            if (br && !j) begin
                m_pht[ix] = tk ? (m_pht[ix] == 3 ? 3 : m_pht[ix] + 1)
                               : (m_pht[ix] == 0 ? 0 : m_pht[ix] - 1);
                m_brc = (m_brc + 1) % 16;
            end
            if (act != pt) begin
                m_pend = 1;
                m_rpc  = act ? tgt : epc + 32'd4;
                m_mpc  = (m_mpc + 1) % 16;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] ipc);
        cyc(0, 0, 0, 0, 0, 0, 0, ipc, 0);
    endtask

    initial begin
        logic [31:0] pcs [6];
        pcs = '{32'h40, 32'h44, 32'h100, 32'h200, 32'h3C, 32'hFFFF_FFFC};
        model_reset();
        bus.ex_valid = 0; bus.ex_is_branch = 0; bus.ex_is_jump = 0;
        bus.ex_pred_taken = 0; bus.branch_tk = 0; bus.ex_pc = 0;
        bus.ex_target = 0; bus.if_pc = 0; bus.stall_in = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        idle(32'h40);
        cyc(1, 1, 0, 0, 1, 32'h40, 32'h80, 32'h40, 0);
        idle(32'h40);
        repeat (3) cyc(1, 1, 0, 1, 1, 32'h40, 32'h80, 32'h40, 0);
        idle(32'h40);
        chk("sat_40", 32'(bus.if_pred_taken), 32'd1);
        cyc(1, 1, 0, 1, 0, 32'h100, 32'h300, 32'h100, 0);
        idle(32'h100);
        cyc(1, 1, 0, 1, 1, 32'h100, 32'h300, 32'h100, 0);
        idle(32'h100);
        cyc(1, 1, 0, 0, 1, 32'h44, 32'h500, 32'h44, 0);
        repeat (3) cyc(1, 1, 0, 0, 1, 32'h48, 32'h600, 32'h48, 1);
        cyc(1, 1, 0, 0, 1, 32'h48, 32'h600, 32'h48, 0);
        idle(32'h48);
        repeat (2) cyc(1, 1, 0, 0, 1, 32'h4C, 32'h700, 32'h4C, 1);
        cyc(1, 1, 0, 0, 1, 32'h4C, 32'h700, 32'h4C, 0);
        idle(32'h4C);
        idle(32'h4C);
        cyc(1, 0, 1, 0, 0, 32'h200, 32'h400, 32'h200, 0);
        idle(32'h200);
        cyc(1, 1, 1, 0, 0, 32'h204, 32'h800, 32'h204, 0);
        idle(32'h204);
        cyc(1, 1, 0, 1, 0, 32'hFFFF_FFFC, 32'h10, 32'h3C, 0);
        idle(32'h3C);
        cyc(1, 1, 0, 0, 1, 32'h40, 32'h90, 32'h40, 0);
        bus.ex_valid = 0; bus.if_pc = 32'h40;
        rst = 1;
        #1;
        model_reset();
        chk("rst_rv",   32'(bus.redirect_valid), 32'd0);
        chk("rst_fl",   32'(bus.flush_if_id),    32'd0);
        chk("rst_rpc",  bus.redirect_pc,         32'd0);
        chk("rst_mpc",  32'(bus.mispred_count),  32'd0);
        chk("rst_pred", 32'(bus.if_pred_taken),  32'd0);
        @(negedge clk);
        rst = 0;
        idle(32'h40);
        for (int n = 0; n < 400; n++) begin
            logic br, j;
            br = $urandom_range(0, 3) != 0;
            j  = $urandom_range(0, 4) == 0;
            cyc(1'($urandom_range(0, 4) != 0), br, j, 1'($urandom), 1'($urandom),
                $urandom_range(0, 1) != 0 ? pcs[$urandom_range(0, 5)] : $urandom & 32'hFFFF_FFFC,
                $urandom, pcs[$urandom_range(0, 5)], 1'($urandom_range(0, 3) == 0));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequences branch resolution for the core pipeline. It consumes the branch comparator's taken flag in EX, compares it with the fetch-time prediction, and issues a registered PC redirect plus IF/ID and ID/EX flushes on a mispredict. It also owns a small bimodal predictor table that is looked up by the fetch PC, and it keeps branch and mispredict performance counters. It sits between the EX-stage branch comparator, the PC/fetch logic and the pipeline-register flush controls.

Parameters:
XLEN, 32, data/PC width
PHT_ENTRIES, 16, number of 2-bit predictor counters; power of 2, at least 2
CNT_W, 32, width of the performance counters

Ports:
clk  input  1  core clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
if_pc  input  XLEN  fetch PC used for the predictor lookup
if_pred_taken  output  1  prediction for if_pc; combinational from the table
ex_valid  input  1  EX holds a valid instruction
ex_is_branch  input  1  EX instruction is a conditional branch (BRA_con != 0)
ex_is_jump  input  1  EX instruction is JAL/JALR
ex_pred_taken  input  1  prediction carried down the pipe with the EX instruction
branch_tk  input  1  taken flag from the branch comparator
ex_pc  input  XLEN  PC of the EX instruction
ex_target  input  XLEN  computed branch/jump target
stall_in  input  1  pipeline frozen this cycle (memory or GEMM accelerator busy)
redirect_valid  output  1  fetch must load redirect_pc
redirect_pc  output  XLEN  corrected PC
flush_if_id  output  1  squash the IF/ID register
flush_id_ex  output  1  squash the ID/EX register
br_count  output  CNT_W  number of resolved conditional branches
mispred_count  output  CNT_W  number of redirects issued

Behaviour:
- Reset (asynchronous, active-high): state IDLE; redirect_valid, flush_if_id and flush_id_ex are 0; redirect_pc is 0; both counters are 0; every predictor entry is 2'b01 (weakly not-taken).
- Resolve event: resolve = state==IDLE & ex_valid & ~stall_in & (ex_is_branch | ex_is_jump). Gating on ~stall_in means each instruction resolves exactly once.
- actual_taken = ex_is_jump | branch_tk.
- mispredict = resolve & (actual_taken != ex_pred_taken). A jump with ex_pred_taken=0 always mispredicts.
- Both ex_is_branch and ex_is_jump set: treat the instruction as a jump. The predictor is not updated and br_count does not increment.
- States:
  - IDLE -> PEND on mispredict. On the same edge, redirect_pc <= actual_taken ? ex_target : ex_pc+4. The +4 add is modulo 2^XLEN, so 0xFFFFFFFC wraps to 0.
  - PEND: redirect_valid=1, flush_if_id=1, flush_id_ex=1, all driven from registered state. If stall_in=0, the redirect is consumed and the next state is IDLE. If stall_in=1, stay in PEND with redirect_pc held.
  - In PEND, EX inputs are ignored: no resolve, no predictor update, no count.
- Latency: mispredict resolved in cycle N gives redirect_valid in cycle N+1. Minimum pulse is 1 cycle; the pulse stretches for as long as stall_in stays high.
- Predictor:
  - Index = pc[$clog2(PHT_ENTRIES)+1:2].
  - On resolve of a conditional branch: increment the entry indexed by ex_pc on taken, decrement on not-taken. Saturate at 2'b11 and 2'b00.
  - if_pred_taken = entry[1].
  - Lookup and update of the same index in the same cycle: lookup returns the old value, and the write lands at the edge.
- Counters:
  - br_count increments on every resolve of a conditional branch.
  - mispred_count increments on every IDLE->PEND transition.
  - Both wrap modulo 2^CNT_W with no saturation.
- Reset asserted mid-PEND: redirect is dropped immediately (asynchronously) and the block returns to IDLE.

Decomposition:
- Package branch_pkg:
  - state enum {IDLE, PEND}
  - BRA_con encodings: BR_NONE=3'b000, BR_EQ=001, BR_NE=010, BR_LT=011, BR_LTU=100, BR_GE=101, BR_GEU=110
  - PHT_INIT=2'b01
- Sub-module bimodal_pht: counter array with asynchronous reset, one combinational read port (lookup) and one synchronous saturating update port. branch_redirect_ctrl instantiates one.

Test Plan:
- Reset, then if_pc=0x40 -> if_pred_taken=0. Beq at ex_pc=0x40, pred 0, branch_tk=1, target 0x80 -> next cycle redirect_valid=1, redirect_pc=0x80, both flushes=1, mispred_count=1, br_count=1. Then three more taken resolves at 0x40 -> entry saturates at 2'b11 and if_pred_taken=1 for 0x40.
- Branch at ex_pc=0x100, pred 1, branch_tk=0 -> redirect_pc=0x104. Correctly predicted branch (pred 1, tk 1) -> no redirect, br_count increments, mispred_count unchanged.
- Mispredict resolved, then stall_in=1 for 3 cycles -> redirect_valid and flushes held for 4 cycles with a stable redirect_pc. A second ex_valid branch during PEND causes no count or predictor change.
- stall_in=1 with a valid mispredicting branch held in EX for 2 cycles, then released -> exactly one resolve: counts +1, single redirect.
- JAL at 0x200, target 0x400, pred 0 -> redirect to 0x400, br_count unchanged, entry for 0x200 unchanged. Not-taken branch at 0xFFFFFFFC with pred 1 -> redirect_pc=0x00000000.
- rst asserted mid-PEND -> outputs 0 at once, table back to 2'b01; mispred_count at 2^CNT_W-1 plus one mispredict (CNT_W=4 build) -> wraps to 0.
